// File: rtl/blob_stats_accum.sv
`timescale 1ns/1ps
// blob_stats_accum: per-channel blob size, centroid and bounding box over a
// frame, snapshotted at frame_end, divided serially, published atomically.
// Ports: clk_65mhz, reset (async, active-high); pixel stream hcount, vcount,
// pix_valid, hit[NCH], frame_end in; result_valid pulse, busy, packed
// per-channel size_out/x_mean/y_mean/x_min/x_max/y_min/y_max/found, and
// overrun_cnt (frames dropped while busy, saturating) out.
module blob_stats_accum #(
  parameter int NCH      = 2,
  parameter int HW       = 11,
  parameter int VW       = 10,
  parameter int ACC_W    = 32,
  parameter int MIN_SIZE = 16
) (
  input  logic                 clk_65mhz,
  input  logic                 reset,
  input  logic [HW-1:0]        hcount,
  input  logic [VW-1:0]        vcount,
  input  logic                 pix_valid,
  input  logic [NCH-1:0]       hit,
  input  logic                 frame_end,
  output logic                 result_valid,
  output logic                 busy,
  output logic [NCH*ACC_W-1:0] size_out,
  output logic [NCH*HW-1:0]    x_mean,
  output logic [NCH*VW-1:0]    y_mean,
  output logic [NCH*HW-1:0]    x_min,
  output logic [NCH*HW-1:0]    x_max,
  output logic [NCH*VW-1:0]    y_min,
  output logic [NCH*VW-1:0]    y_max,
  output logic [NCH-1:0]       found,
  output logic [7:0]           overrun_cnt
);

  localparam int ND = 2 * NCH;
  localparam int IW = $clog2(ND);
  localparam int CW = $clog2(ACC_W);

  typedef enum logic [1:0] {ACC, SNAP, DIV, PUB} state_t;
  state_t state;

  logic [ACC_W-1:0] a_size [NCH];
  logic [ACC_W-1:0] a_xs   [NCH];
  logic [ACC_W-1:0] a_ys   [NCH];
  logic [HW-1:0]    a_xmin [NCH];
  logic [HW-1:0]    a_xmax [NCH];
  logic [VW-1:0]    a_ymin [NCH];
  logic [VW-1:0]    a_ymax [NCH];

  logic [ACC_W-1:0] n_size [NCH];
  logic [ACC_W-1:0] n_xs   [NCH];
  logic [ACC_W-1:0] n_ys   [NCH];
  logic [HW-1:0]    n_xmin [NCH];
  logic [HW-1:0]    n_xmax [NCH];
  logic [VW-1:0]    n_ymin [NCH];
  logic [VW-1:0]    n_ymax [NCH];

  logic [ACC_W-1:0] s_size [NCH];
  logic [ACC_W-1:0] s_xs   [NCH];
  logic [ACC_W-1:0] s_ys   [NCH];
  logic [HW-1:0]    s_xmin [NCH];
  logic [HW-1:0]    s_xmax [NCH];
  logic [VW-1:0]    s_ymin [NCH];
  logic [VW-1:0]    s_ymax [NCH];

  logic [HW-1:0]    mx [NCH];
  logic [VW-1:0]    my [NCH];
  logic [HW-1:0]    fx [NCH];
  logic [VW-1:0]    fy [NCH];

  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] dq;
  logic [ACC_W-1:0] dr;
  logic [ACC_W-1:0] dd;
  logic [ACC_W:0]   trial;
  logic [ACC_W-1:0] diff;
  logic [ACC_W-1:0] q_step;
  logic [ACC_W-1:0] r_step;
  logic             fits;
  logic             last;
  int               ch;
  int               nch;

  assign busy = (state != ACC);

  function automatic logic [ACC_W-1:0] sat_add(
    input logic [ACC_W-1:0] a,
    input logic [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? '1 : s[ACC_W-1:0];
  endfunction

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      n_size[c] = a_size[c];
      n_xs[c]   = a_xs[c];
      n_ys[c]   = a_ys[c];
      n_xmin[c] = a_xmin[c];
      n_xmax[c] = a_xmax[c];
      n_ymin[c] = a_ymin[c];
      n_ymax[c] = a_ymax[c];
      if (pix_valid && hit[c]) begin
        n_size[c] = sat_add(a_size[c], ACC_W'(1));
        n_xs[c]   = sat_add(a_xs[c], ACC_W'(hcount));
        n_ys[c]   = sat_add(a_ys[c], ACC_W'(vcount));
        if (hcount < a_xmin[c]) n_xmin[c] = hcount;
        if (hcount > a_xmax[c]) n_xmax[c] = hcount;
        if (vcount < a_ymin[c]) n_ymin[c] = vcount;
        if (vcount > a_ymax[c]) n_ymax[c] = vcount;
      end
    end
  end

  // The frame_end pixel is folded in before the snapshot; a frame_end
  // while busy only clears the running frame and bumps overrun_cnt.
  always_ff @(posedge clk_65mhz or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        a_size[c] <= '0;
        a_xs[c]   <= '0;
        a_ys[c]   <= '0;
        a_xmin[c] <= '1;
        a_xmax[c] <= '0;
        a_ymin[c] <= '1;
        a_ymax[c] <= '0;
        s_size[c] <= '0;
        s_xs[c]   <= '0;
        s_ys[c]   <= '0;
        s_xmin[c] <= '0;
        s_xmax[c] <= '0;
        s_ymin[c] <= '0;
        s_ymax[c] <= '0;
      end
      overrun_cnt <= '0;
    end else if (frame_end) begin
      for (int c = 0; c < NCH; c++) begin
        a_size[c] <= '0;
        a_xs[c]   <= '0;
        a_ys[c]   <= '0;
        a_xmin[c] <= '1;
        a_xmax[c] <= '0;
        a_ymin[c] <= '1;
        a_ymax[c] <= '0;
        if (!busy) begin
          s_size[c] <= n_size[c];
          s_xs[c]   <= n_xs[c];
          s_ys[c]   <= n_ys[c];
          s_xmin[c] <= n_xmin[c];
          s_xmax[c] <= n_xmax[c];
          s_ymin[c] <= n_ymin[c];
          s_ymax[c] <= n_ymax[c];
        end
      end
      if (busy && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        a_size[c] <= n_size[c];
        a_xs[c]   <= n_xs[c];
        a_ys[c]   <= n_ys[c];
        a_xmin[c] <= n_xmin[c];
        a_xmax[c] <= n_xmax[c];
        a_ymin[c] <= n_ymin[c];
        a_ymax[c] <= n_ymax[c];
      end
    end
  end

  // Restoring divider: dq starts as the dividend and shifts the quotient
  // in from the bottom; the remainder never exceeds the divisor.
  always_comb begin
    ch     = int'(idx >> 1);
    nch    = (ch + 1 < NCH) ? ch + 1 : ch;
    dd     = s_size[ch];
    trial  = {dr, dq[ACC_W-1]};
    fits   = (trial >= {1'b0, dd});
    diff   = trial[ACC_W-1:0] - dd;
    q_step = {dq[ACC_W-2:0], fits};
    r_step = fits ? diff : trial[ACC_W-1:0];
    last   = (cnt == CW'(ACC_W - 1));
    for (int c = 0; c < NCH; c++) begin
      fx[c] = mx[c];
      fy[c] = my[c];
    end
    if (state == DIV && last) begin
      if (idx[0])
        fy[ch] = (dd == '0) ? '0 : q_step[VW-1:0];
      else
        fx[ch] = (dd == '0) ? '0 : q_step[HW-1:0];
    end
  end

  always_ff @(posedge clk_65mhz or posedge reset) begin
    if (reset) begin
      state        <= ACC;
      idx          <= '0;
      cnt          <= '0;
      dq           <= '0;
      dr           <= '0;
      result_valid <= 1'b0;
      size_out     <= '0;
      x_mean       <= '0;
      y_mean       <= '0;
      x_min        <= '0;
      x_max        <= '0;
      y_min        <= '0;
      y_max        <= '0;
      found        <= '0;
      for (int c = 0; c < NCH; c++) begin
        mx[c] <= '0;
        my[c] <= '0;
      end
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        ACC: begin
          if (frame_end) state <= SNAP;
        end
        SNAP: begin
          state <= DIV;
          idx   <= '0;
          cnt   <= '0;
          dq    <= s_xs[0];
          dr    <= '0;
        end
        DIV: begin
          mx <= fx;
          my <= fy;
          if (last) begin
            cnt <= '0;
            dr  <= '0;
            if (idx == IW'(ND - 1)) begin
              state        <= PUB;
              result_valid <= 1'b1;
              for (int c = 0; c < NCH; c++) begin
                size_out[c*ACC_W +: ACC_W] <= s_size[c];
                x_mean[c*HW +: HW] <= fx[c];
                y_mean[c*VW +: VW] <= fy[c];
                x_min[c*HW +: HW] <= (s_size[c] == '0) ? '0 : s_xmin[c];
                x_max[c*HW +: HW] <= s_xmax[c];
                y_min[c*VW +: VW] <= (s_size[c] == '0) ? '0 : s_ymin[c];
                y_max[c*VW +: VW] <= s_ymax[c];
                found[c] <= (s_size[c] >= ACC_W'(MIN_SIZE));
              end
            end else begin
              idx <= idx + IW'(1);
              dq  <= idx[0] ? s_xs[nch] : s_ys[ch];
            end
          end else begin
            cnt <= cnt + CW'(1);
            dq  <= q_step;
            dr  <= r_step;
          end
        end
        PUB: begin
          state <= ACC;
        end
      endcase
    end
  end

endmodule
